// File: rtl/simon_pkg.sv
// Shared types and limits for the Simon pattern-playback block.
package simon_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} seqplay_state_t;

  localparam int MAXDIG = 8;

endpackage

// File: rtl/seqplay_if.sv
// Controller-to-playback bundle: pattern request going in, display outputs coming out.
interface seqplay_if #(
  parameter int NDIG = simon_pkg::MAXDIG
);

  logic              start;
  logic [4*NDIG-1:0] pattern;
  logic [3:0]        len;
  logic [3:0]        digit;
  logic              show;
  logic              busy;
  logic              done;

  modport master (
    output start, pattern, len,
    input  digit, show, busy, done
  );

  modport slave (
    input  start, pattern, len,
    output digit, show, busy, done
  );

endinterface

// File: rtl/seqplay_timer.sv
// Loadable down-counter that parks at zero; times the on and off display windows.
module seqplay_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] loadVal_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seqplay.sv
// Simon playback: shows a captured pattern one digit at a time with timed on/off windows.
module seqplay
  import simon_pkg::*;
#(
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1,
  parameter int NDIG      = MAXDIG
) (
  input  logic     clk,
  input  logic     rst,
  seqplay_if.slave bus
);

  localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(MAXT) + 1;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_TICKS - 1);

  seqplay_state_t    state_q, state_d;
  logic [4*NDIG-1:0] pattern_q, pattern_d;
  logic [IW-1:0]     index_q, index_d;
  logic [3:0]        digit_q, digit_d;
  logic              show_q, show_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tmrLoad;
  logic [TW-1:0]     tmrLoadVal;
  logic              tmrZero;
  logic [4:0]        effLen;

  // Lengths beyond the pattern capacity play the whole pattern.
  assign effLen = ({1'b0, bus.len} > 5'(NDIG)) ? 5'(NDIG) : {1'b0, bus.len};

  seqplay_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmrLoad),
    .loadVal_i (tmrLoadVal),
    .zero_o    (tmrZero)
  );

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    index_d    = index_q;
    done_d     = 1'b0;
    tmrLoad    = 1'b0;
    tmrLoadVal = ON_LOAD;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (effLen != 5'd0) begin
            pattern_d = bus.pattern;
            index_d   = IW'(effLen - 5'd1);
            tmrLoad   = 1'b1;
            state_d   = SHOW;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHOW: begin
        if (tmrZero) begin
          tmrLoad    = 1'b1;
          tmrLoadVal = OFF_LOAD;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (tmrZero) begin
          if (index_q != '0) begin
            index_d = index_q - 1'b1;
            tmrLoad = 1'b1;
            state_d = SHOW;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    show_d  = (state_d == SHOW);
    busy_d  = (state_d != IDLE);
    digit_d = show_d ? pattern_d[index_d*4 +: 4] : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      index_q   <= '0;
      digit_q   <= 4'd0;
      show_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      index_q   <= index_d;
      digit_q   <= digit_d;
      show_q    <= show_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.digit = digit_q;
  assign bus.show  = show_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seqplay.sv
// Directed bench for seqplay with ON_TICKS=2, OFF_TICKS=1, NDIG=8.
module tb_seqplay;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seqplay_if #(.NDIG(8)) bus ();

  seqplay #(.ON_TICKS(2), .OFF_TICKS(1), .NDIG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic [31:0] p, input logic [3:0] l);
    bus.start   = s;
    bus.pattern = p;
    bus.len     = l;
  endtask

  // Advance one rising edge, then sample on the following falling edge.
  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic expShow, input logic [3:0] expDigit,
                             input logic expBusy, input logic expDone);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {bus.show, bus.digit, bus.busy, bus.done};
    exp = {expShow, expDigit, expBusy, expDone};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed show/digit/busy/done=%b/%h/%b/%b expected %b/%h/%b/%b",
             tag, obs[6], obs[5:2], obs[1], obs[0], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Called in the first SHOW cycle; seq holds the expected digits, first one in [31:28].
  task automatic checkPlayback(input string tag, input logic [31:0] seq, input int n);
    logic [31:0] s;
    s = seq;
    for (int k = 0; k < n; k++) begin
      checkOutput({tag, " on1"}, 1'b1, s[31:28], 1'b1, 1'b0);
      nextCycle();
      checkOutput({tag, " on2"}, 1'b1, s[31:28], 1'b1, 1'b0);
      nextCycle();
      checkOutput({tag, " gap"}, 1'b0, 4'd0, 1'b1, 1'b0);
      nextCycle();
      s = s << 4;
    end
    checkOutput({tag, " done"}, 1'b0, 4'd0, 1'b0, 1'b1);
    nextCycle();
    checkOutput({tag, " idle"}, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(1'b1, 32'h0000_0912, 4'd3);

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("reset", 1'b0, 4'd0, 1'b0, 1'b0);
      nextCycle();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0000_0912, 4'd3);
    nextCycle();
    checkOutput("post-reset idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // Basic playback written out cycle by cycle.
    applyStimulus(1'b1, 32'h0000_0912, 4'd3);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0000, 4'd0);
    checkOutput("basic c1", 1'b1, 4'h9, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c2", 1'b1, 4'h9, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c3", 1'b0, 4'h0, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c4", 1'b1, 4'h1, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c5", 1'b1, 4'h1, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c6", 1'b0, 4'h0, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c7", 1'b1, 4'h2, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c8", 1'b1, 4'h2, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c9", 1'b0, 4'h0, 1'b1, 1'b0); nextCycle();
    checkOutput("basic c10", 1'b0, 4'h0, 1'b0, 1'b1); nextCycle();
    checkOutput("basic c11", 1'b0, 4'h0, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'h8765_4321, 4'd8);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0000, 4'd0);
    checkPlayback("full8", 32'h8765_4321, 8);

    applyStimulus(1'b1, 32'h8765_4321, 4'd12);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0000, 4'd0);
    checkPlayback("clamp12", 32'h8765_4321, 8);

    applyStimulus(1'b1, 32'h1234_5678, 4'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0000, 4'd0);
    checkOutput("len0 done", 1'b0, 4'd0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("len0 idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // Start and pattern changes during playback must not disturb the captured copy.
    applyStimulus(1'b1, 32'h0000_00AB, 4'd2);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_00AB, 4'd2);
    checkOutput("busyign c1", 1'b1, 4'hA, 1'b1, 1'b0); nextCycle();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 4'd8);
    checkOutput("busyign c2", 1'b1, 4'hA, 1'b1, 1'b0); nextCycle();
    checkOutput("busyign c3", 1'b0, 4'h0, 1'b1, 1'b0); nextCycle();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 4'd8);
    checkOutput("busyign c4", 1'b1, 4'hB, 1'b1, 1'b0); nextCycle();
    checkOutput("busyign c5", 1'b1, 4'hB, 1'b1, 1'b0); nextCycle();
    checkOutput("busyign c6", 1'b0, 4'h0, 1'b1, 1'b0); nextCycle();
    checkOutput("busyign c7", 1'b0, 4'h0, 1'b0, 1'b1); nextCycle();
    checkOutput("busyign c8", 1'b0, 4'h0, 1'b0, 1'b0); nextCycle();
    checkOutput("busyign c9", 1'b0, 4'h0, 1'b0, 1'b0);

    // Start held high: restart on the done cycle, back to back.
    applyStimulus(1'b1, 32'h0000_0003, 4'd1);
    nextCycle();
    checkOutput("held c1", 1'b1, 4'h3, 1'b1, 1'b0); nextCycle();
    checkOutput("held c2", 1'b1, 4'h3, 1'b1, 1'b0); nextCycle();
    checkOutput("held c3", 1'b0, 4'h0, 1'b1, 1'b0); nextCycle();
    checkOutput("held c4", 1'b0, 4'h0, 1'b0, 1'b1); nextCycle();
    applyStimulus(1'b0, 32'h0000_0000, 4'd0);
    checkOutput("held c5", 1'b1, 4'h3, 1'b1, 1'b0); nextCycle();
    checkOutput("held c6", 1'b1, 4'h3, 1'b1, 1'b0); nextCycle();
    checkOutput("held c7", 1'b0, 4'h0, 1'b1, 1'b0); nextCycle();
    checkOutput("held c8", 1'b0, 4'h0, 1'b0, 1'b1); nextCycle();
    checkOutput("held c9", 1'b0, 4'h0, 1'b0, 1'b0);

    // Asynchronous reset during the second SHOW window.
    applyStimulus(1'b1, 32'h0000_0912, 4'd3);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0000, 4'd0);
    checkOutput("midrst c1", 1'b1, 4'h9, 1'b1, 1'b0); nextCycle();
    checkOutput("midrst c2", 1'b1, 4'h9, 1'b1, 1'b0); nextCycle();
    checkOutput("midrst c3", 1'b0, 4'h0, 1'b1, 1'b0); nextCycle();
    checkOutput("midrst c4", 1'b1, 4'h1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("midrst async", 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst held", 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    nextCycle();
    checkOutput("midrst idle", 1'b0, 4'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'h0000_0005, 4'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0000, 4'd0);
    checkPlayback("after rst", 32'h5000_0000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
